// File: rtl/voltage_disp_pkg.sv
// Shared definitions for the voltage display path: FSM encoding, default
// geometry of the BCD converter and the iteration counter width helper.
package voltage_disp_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } conv_state_e;

    localparam int unsigned IN_W_DEF    = 16;
    localparam int unsigned DIGITS_DEF  = 4;
    localparam int unsigned MAX_VAL_DEF = 9999;
    localparam int unsigned DP_POS_DEF  = 2;

    // Width of a counter that has to reach n-1 (never narrower than 1 bit).
    function automatic int unsigned iter_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is >= 5
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional add-3 correction.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/voltage_bcd_convert.sv
// Converts the calibrated voltage word (volts x100) to packed BCD digits with
// a sequential double-dabble loop, and derives the leading-zero blank mask and
// decimal-point mask for the seven-segment scan driver. A single pending slot
// catches a strobe that arrives while a conversion is in flight.
module voltage_bcd_convert
    import voltage_disp_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned DIGITS  = DIGITS_DEF,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF,
    parameter int unsigned DP_POS  = DP_POS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       voltage,
    input  logic                  voltage_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     dp_mask,
    output logic                  overrange,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned SR_W   = BCD_W + IN_W;
    localparam int unsigned ITER_W = iter_width(IN_W);

    localparam logic [IN_W-1:0]   MAX_V     = IN_W'(MAX_VAL);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(IN_W - 1);
    localparam logic [DIGITS-1:0] DP_MASK   = DIGITS'(1 << DP_POS);
    // Digits above the decimal point start out blanked (display shows "0.00").
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'((1 << (DP_POS + 1)) - 1);

    conv_state_e          state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic [IN_W-1:0]      pend_q, pend_d;
    logic                 pend_flag_q, pend_flag_d;
    logic                 ovr_q, ovr_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0]    blank_q, blank_d;
    logic                 overrange_q, overrange_d;
    logic                 bcd_valid_q, bcd_valid_d;

    logic [BCD_W-1:0]     adj;
    logic [SR_W-1:0]      shifted;
    logic [BCD_W-1:0]     final_bcd;
    logic [DIGITS-1:0]    blank_calc;
    logic                 load;
    logic [IN_W-1:0]      load_src;

    function automatic logic [IN_W-1:0] clamp(input logic [IN_W-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Per-digit add-3 correction ahead of every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr_q[IN_W + 4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign shifted   = {adj[BCD_W-2:0], sr_q[IN_W-1:0], 1'b0};
    assign final_bcd = sr_q[SR_W-1 -: BCD_W];

    // Leading-zero suppression: only digits above the decimal point may blank.
    always_comb begin
        logic above;
        blank_calc = '0;
        above      = 1'b1;
        for (int i = int'(DIGITS) - 1; i > int'(DP_POS); i--) begin
            blank_calc[i] = above && (final_bcd[4*i +: 4] == 4'd0);
            above         = blank_calc[i];
        end
    end

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        iter_d      = iter_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        ovr_d       = ovr_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        overrange_d = overrange_q;
        bcd_valid_d = 1'b0;
        load        = 1'b0;
        load_src    = voltage;

        unique case (state_q)
            StIdle: begin
                if (voltage_valid) begin
                    load    = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                sr_d   = shifted;
                iter_d = iter_q + 1'b1;
                if (iter_q == LAST_ITER) begin
                    state_d = StDone;
                end
                // Newest strobe wins; an older pending value is dropped.
                if (voltage_valid) begin
                    pend_d      = voltage;
                    pend_flag_d = 1'b1;
                end
            end
            StDone: begin
                bcd_d       = final_bcd;
                blank_d     = blank_calc;
                overrange_d = ovr_q;
                bcd_valid_d = 1'b1;
                // A live strobe outranks the pending slot, which is then discarded.
                if (voltage_valid) begin
                    load        = 1'b1;
                    pend_flag_d = 1'b0;
                    state_d     = StShift;
                end else if (pend_flag_q) begin
                    load        = 1'b1;
                    load_src    = pend_q;
                    pend_flag_d = 1'b0;
                    state_d     = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            sr_d   = {{BCD_W{1'b0}}, clamp(load_src)};
            ovr_d  = (load_src > MAX_V);
            iter_d = '0;
        end
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            iter_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            ovr_q       <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
            overrange_q <= 1'b0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            iter_q      <= iter_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            ovr_q       <= ovr_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            overrange_q <= overrange_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign dp_mask   = DP_MASK;
    assign overrange = overrange_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_voltage_bcd_convert.sv
// Directed bench for voltage_bcd_convert with hand-computed expected values.
module tb_voltage_bcd_convert;

    logic        clk;
    logic        rst_n;
    logic [15:0] voltage;
    logic        voltage_valid;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  dp_mask;
    logic        overrange;
    logic        bcd_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    voltage_bcd_convert u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .voltage       (voltage),
        .voltage_valid (voltage_valid),
        .bcd           (bcd),
        .blank         (blank),
        .dp_mask       (dp_mask),
        .overrange     (overrange),
        .bcd_valid     (bcd_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives a one-cycle strobe, returns at the next negedge.
    task automatic pulse(input logic [15:0] v);
        voltage       = v;
        voltage_valid = 1'b1;
        @(negedge clk);
        voltage_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Steps at least one cycle, stops at the negedge where bcd_valid is seen.
    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bcd_valid && cyc < 100);
        check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bcd_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic convert(input string tag, input logic [15:0] v, input logic [15:0] exp_bcd,
                           input logic [3:0] exp_blank, input logic exp_ovr);
        int cyc;
        pulse(v);
        wait_valid(tag, cyc);
        check({tag, "_lat"},   32'(cyc), 32'd17);
        check({tag, "_bcd"},   32'(bcd), 32'(exp_bcd));
        check({tag, "_blank"}, 32'(blank), 32'(exp_blank));
        check({tag, "_ovr"},   32'(overrange), 32'(exp_ovr));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bcd_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n         = 1'b0;
        voltage       = '0;
        voltage_valid = 1'b0;
        idle(2);
        check("rst_bcd",   32'(bcd), 32'h0);
        check("rst_blank", 32'(blank), 32'h8);
        check("rst_dp",    32'(dp_mask), 32'h4);
        check("rst_ovr",   32'(overrange), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic conversion and latency.
        convert("v500", 16'd500, 16'h0500, 4'b1000, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);

        convert("v0",    16'd0,    16'h0000, 4'b1000, 1'b0);
        convert("v5",    16'd5,    16'h0005, 4'b1000, 1'b0);
        convert("v9999", 16'd9999, 16'h9999, 4'b0000, 1'b0);
        convert("v1234", 16'd1234, 16'h1234, 4'b0000, 1'b0);
        convert("vffff", 16'hFFFF, 16'h9999, 4'b0000, 1'b1);
        convert("v123",  16'd123,  16'h0123, 4'b1000, 1'b0);
        convert("v10000", 16'd10000, 16'h9999, 4'b0000, 1'b1);
        check("dp_const", 32'(dp_mask), 32'h4);

        // Strobes during SHIFT: newest pending wins, 200 is dropped.
        pulse(16'd100);
        check("shift_busy", 32'(busy), 32'd1);
        idle(2);
        pulse(16'd200);
        idle(2);
        pulse(16'd300);
        wait_valid("pend_a", cyc);
        check("pend_a_lat", 32'(cyc), 32'd11);
        check("pend_a_bcd", 32'(bcd), 32'h0100);
        wait_valid("pend_b", cyc);
        check("pend_b_lat", 32'(cyc), 32'd17);
        check("pend_b_bcd", 32'(bcd), 32'h0300);
        quiet("pend_quiet", 40);

        // Strobe on the DONE edge outranks the pending 400.
        pulse(16'd111);
        idle(4);
        pulse(16'd400);
        idle(11);
        pulse(16'd250);
        check("done_valid", 32'(bcd_valid), 32'd1);
        check("done_bcd",   32'(bcd), 32'h0111);
        wait_valid("prio", cyc);
        check("prio_lat", 32'(cyc), 32'd17);
        check("prio_bcd", 32'(bcd), 32'h0250);
        quiet("prio_quiet", 40);

        // Reset in the middle of a conversion.
        pulse(16'd777);
        idle(8);
        rst_n = 1'b0;
        idle(1);
        check("mid_bcd",   32'(bcd), 32'h0);
        check("mid_blank", 32'(blank), 32'h8);
        check("mid_ovr",   32'(overrange), 32'd0);
        check("mid_valid", 32'(bcd_valid), 32'd0);
        check("mid_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        quiet("abort_quiet", 30);
        convert("v42", 16'd42, 16'h0042, 4'b1000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
